// File: rtl/disptiming_pkg.sv
// Shared types and constants for the raster timing generator.
// Default timing is 640x480@60 from a 50 MHz clock (two clocks per pixel).
package disptiming_pkg;

   localparam int POS_W = 12;

   // Segment order within a line or frame; the blanking segments follow the active one
   typedef enum logic [1:0] {
      ST_ACT  = 2'd0,
      ST_FP   = 2'd1,
      ST_SYNC = 2'd2,
      ST_BP   = 2'd3
   } axis_state_t;

   localparam int DEF_CKE_DIV = 2;

   localparam int DEF_H_ACT  = 640;
   localparam int DEF_H_FP   = 16;
   localparam int DEF_H_SYNC = 96;
   localparam int DEF_H_BP   = 48;

   localparam int DEF_V_ACT  = 480;
   localparam int DEF_V_FP   = 10;
   localparam int DEF_V_SYNC = 2;
   localparam int DEF_V_BP   = 33;

   function automatic axis_state_t next_seg(input axis_state_t s);
      axis_state_t n;
      n = ST_ACT;
      case (s)
         ST_ACT:  n = ST_FP;
         ST_FP:   n = ST_SYNC;
         ST_SYNC: n = ST_BP;
         ST_BP:   n = ST_ACT;
         default: n = ST_ACT;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/disptiming_axis.sv
// One raster axis: walks ACT -> FP -> SYNC -> BP with a per-segment counter and
// a position counter. Publishes the next-state so the top can register decodes.
module disptiming_axis
   import disptiming_pkg::*;
#(
   parameter int ACT  = DEF_H_ACT,
   parameter int FP   = DEF_H_FP,
   parameter int SYNC = DEF_H_SYNC,
   parameter int BP   = DEF_H_BP
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_adv,
   output logic [POS_W-1:0] o_pos,
   output axis_state_t      o_state,
   output logic             o_wrap
);

   localparam int TOT = ACT + FP + SYNC + BP;

   localparam logic [POS_W-1:0] ACT_M1  = POS_W'(ACT - 1);
   localparam logic [POS_W-1:0] FP_M1   = POS_W'(FP - 1);
   localparam logic [POS_W-1:0] SYNC_M1 = POS_W'(SYNC - 1);
   localparam logic [POS_W-1:0] BP_M1   = POS_W'(BP - 1);
   localparam logic [POS_W-1:0] TOT_M1  = POS_W'(TOT - 1);

   axis_state_t      r_state;
   axis_state_t      w_state_next;
   logic [POS_W-1:0] r_cnt;
   logic [POS_W-1:0] w_cnt_next;
   logic [POS_W-1:0] r_pos;
   logic [POS_W-1:0] w_pos_next;
   logic [POS_W-1:0] w_seg_last;
   logic             w_at_end;

   always_comb begin
      w_seg_last = BP_M1;
      case (r_state)
         ST_ACT:  w_seg_last = ACT_M1;
         ST_FP:   w_seg_last = FP_M1;
         ST_SYNC: w_seg_last = SYNC_M1;
         ST_BP:   w_seg_last = BP_M1;
         default: w_seg_last = BP_M1;
      endcase
   end

   assign w_at_end = (r_cnt == w_seg_last);
   // Leaving the last back-porch slot is the only way back to position 0
   assign o_wrap   = i_adv & w_at_end & (r_state == ST_BP);

   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      w_pos_next   = r_pos;
      if (i_adv) begin
         if (w_at_end) begin
            w_state_next = next_seg(r_state);
            w_cnt_next   = '0;
         end else begin
            w_cnt_next = r_cnt + POS_W'(1);
         end
         w_pos_next = o_wrap ? '0 : (r_pos + POS_W'(1));
      end
   end

   // Reset parks on the final back-porch slot so the first advance lands on (0)
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= ST_BP;
         r_cnt   <= BP_M1;
         r_pos   <= TOT_M1;
      end else begin
         r_state <= w_state_next;
         r_cnt   <= w_cnt_next;
         r_pos   <= w_pos_next;
      end
   end

   assign o_pos   = r_pos;
   assign o_state = w_state_next;

endmodule

// File: rtl/disptiming.sv
// Raster timing generator: pixel clock-enable divider plus registered
// sync/blank/position stream, all advancing on the same enable.
module disptiming
   import disptiming_pkg::*;
#(
   parameter int   CKE_DIV = DEF_CKE_DIV,
   parameter int   H_ACT   = DEF_H_ACT,
   parameter int   H_FP    = DEF_H_FP,
   parameter int   H_SYNC  = DEF_H_SYNC,
   parameter int   H_BP    = DEF_H_BP,
   parameter int   V_ACT   = DEF_V_ACT,
   parameter int   V_FP    = DEF_V_FP,
   parameter int   V_SYNC  = DEF_V_SYNC,
   parameter int   V_BP    = DEF_V_BP,
   parameter logic HS_POL  = 1'b0,
   parameter logic VS_POL  = 1'b0
) (
   input  logic             CLK,
   input  logic             RST,
   output logic             TX_CLK,
   output logic             TX_HS,
   output logic             TX_VS,
   output logic             TX_DE,
   output logic             TX_FS,
   output logic [POS_W-1:0] H_POS,
   output logic [POS_W-1:0] V_POS
);

   localparam logic [3:0] DIV_LAST = 4'(CKE_DIV - 1);

   logic [3:0]       r_div;
   logic [3:0]       w_div_next;
   logic             r_tx_clk;
   logic             r_de;
   logic             r_hs;
   logic             r_vs;
   logic             r_fs;

   axis_state_t      w_h_state;
   axis_state_t      w_v_state;
   logic [POS_W-1:0] w_h_pos;
   logic [POS_W-1:0] w_v_pos;
   logic             w_h_wrap;
   logic             w_v_wrap;

   assign w_div_next = (r_div == DIV_LAST) ? 4'd0 : (r_div + 4'd1);

   // Enable is registered from the divider's next value so it is high while div==CKE_DIV-1
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_div    <= 4'd0;
         r_tx_clk <= 1'b0;
      end else begin
         r_div    <= w_div_next;
         r_tx_clk <= (w_div_next == DIV_LAST);
      end
   end

   disptiming_axis #(
      .ACT  (H_ACT),
      .FP   (H_FP),
      .SYNC (H_SYNC),
      .BP   (H_BP)
   ) u_h_axis (
      .i_clk   (CLK),
      .i_rst   (RST),
      .i_adv   (r_tx_clk),
      .o_pos   (w_h_pos),
      .o_state (w_h_state),
      .o_wrap  (w_h_wrap)
   );

   disptiming_axis #(
      .ACT  (V_ACT),
      .FP   (V_FP),
      .SYNC (V_SYNC),
      .BP   (V_BP)
   ) u_v_axis (
      .i_clk   (CLK),
      .i_rst   (RST),
      .i_adv   (w_h_wrap),
      .o_pos   (w_v_pos),
      .o_state (w_v_state),
      .o_wrap  (w_v_wrap)
   );

   // Decoding next-state keeps these flops aligned with the position registers.
   // A vertical wrap only happens together with a horizontal one, i.e. entry to (0,0).
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_de <= 1'b0;
         r_fs <= 1'b0;
         r_hs <= ~HS_POL;
         r_vs <= ~VS_POL;
      end else if (r_tx_clk) begin
         r_de <= (w_h_state == ST_ACT) && (w_v_state == ST_ACT);
         r_fs <= w_v_wrap;
         r_hs <= (w_h_state == ST_SYNC) ? HS_POL : ~HS_POL;
         r_vs <= (w_v_state == ST_SYNC) ? VS_POL : ~VS_POL;
      end
   end

   assign TX_CLK = r_tx_clk;
   assign TX_DE  = r_de;
   assign TX_FS  = r_fs;
   assign TX_HS  = r_hs;
   assign TX_VS  = r_vs;
   assign H_POS  = w_h_pos;
   assign V_POS  = w_v_pos;

endmodule
